// File: rtl/gdo_pkg.sv
// Shared Q(DATA_W/2).(DATA_W/2) fixed-point helpers and constants for the
// gradient-descent output-layer blocks.
package gdo;
    localparam int DATA_W    = 16;
    localparam int FRAC_BITS = DATA_W / 2;

    typedef logic signed [DATA_W-1:0] word_t;

    localparam word_t ONE        = word_t'(1 << FRAC_BITS);
    localparam word_t LR_DEFAULT = 16'h0020;

    // Full-precision product, arithmetic shift back to the word scale and
    // truncate (floor); overflow wraps.
    function automatic word_t gdo_mult(word_t a, word_t b);
        logic signed [2*DATA_W-1:0] p;
        p = a * b;
        return p[FRAC_BITS +: DATA_W];
    endfunction

    function automatic word_t gdo_sub(word_t a, word_t b);
        return a - b;
    endfunction

    // w - lr*(d*a); with a = ONE this is the bias step.
    function automatic word_t weight_step(word_t w, word_t d, word_t a, word_t lr);
        return gdo_sub(w, gdo_mult(lr, gdo_mult(d, a)));
    endfunction
endpackage

// File: rtl/output_layer_update_weight_step_pe.sv
// Combinational single-weight gradient step: w_new = w - lr*d*a.
module weight_step_pe
    import gdo::*;
(
    input  word_t w,
    input  word_t d,
    input  word_t a,
    input  word_t lr,
    output word_t w_new
);
    assign w_new = weight_step(w, d, a, lr);
endmodule

// File: rtl/output_layer_update.sv
// Serial output-layer weight/bias update: one weight per cycle, bias of row i
// updated alongside its first weight, done pulse when the last weight lands.
module output_layer_update
    import gdo::*;
#(
    parameter int                  size          = 3,
    parameter int                  input_size    = 3,
    // gdo helpers are built at gdo::DATA_W; keep data_size equal to it.
    parameter int                  data_size     = gdo::DATA_W,
    parameter logic [data_size-1:0] learning_rate = gdo::LR_DEFAULT
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [size*data_size-1:0]              diff,
    input  logic [input_size*data_size-1:0]        activation,
    input  logic [size*input_size*data_size-1:0]   weight_in,
    input  logic [size*data_size-1:0]              bias_in,
    output logic [size*input_size*data_size-1:0]   weight_out,
    output logic [size*data_size-1:0]              bias_out,
    output logic                                   busy,
    output logic                                   done
);
    localparam int NW = size * input_size;
    localparam int IW = (size > 1) ? $clog2(size) : 1;
    localparam int JW = (input_size > 1) ? $clog2(input_size) : 1;
    localparam int KW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

    state_t                              state;
    logic [IW-1:0]                       i;
    logic [JW-1:0]                       j;
    logic [KW-1:0]                       k;   // flat weight index, tracks i*input_size+j
    logic [size-1:0][data_size-1:0]      d_r;
    logic [input_size-1:0][data_size-1:0] a_r;
    logic [NW-1:0][data_size-1:0]        w_r;
    logic [size-1:0][data_size-1:0]      b_r;
    word_t                               w_next;
    word_t                               b_next;

    weight_step_pe pe (
        .w    (w_r[k]),
        .d    (d_r[i]),
        .a    (a_r[j]),
        .lr   (learning_rate),
        .w_new(w_next)
    );

    assign b_next     = weight_step(b_r[i], d_r[i], ONE, learning_rate);
    assign weight_out = w_r;
    assign bias_out   = b_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d_r   <= '0;
            a_r   <= '0;
            w_r   <= '0;
            b_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        d_r   <= diff;
                        a_r   <= activation;
                        w_r   <= weight_in;
                        b_r   <= bias_in;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    w_r[k] <= w_next;
                    if (j == '0)
                        b_r[i] <= b_next;
                    k <= k + 1'b1;
                    if (j == JW'(input_size - 1)) begin
                        j <= '0;
                        if (i == IW'(size - 1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
